buffer_unloader: RTL and testbench

Downstream stage of the K-in/J-out circular buffer datapath. Pulls one J-word block from the buffer whenever the buffer is not empty and the block is idle or about to finish its current block. It then serialises that block onto a single WIDTH-bit stream with a valid/ready handshake. It also drives the buffer's read-pointer load strobe (ld3) directly.

---
 rtl/buffer_pkg.sv | 19 +
 rtl/word_select.sv | 26 ++
 rtl/buffer_unloader.sv | 95 +++++++++
 tb/tb_buffer_unloader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/buffer_pkg.sv
// Shared definitions for the K-in/J-out circular buffer datapath.
// Holds the default word width and block size shared with the buffer,
// the unloader state encoding, and the word-index width helper.
package buffer_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultJ     = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Word-index counter width; a one-word block still needs a 1-bit index.
  function automatic int unsigned cw_of(input int unsigned j);
    return (j > 1) ? $clog2(j) : 1;
  endfunction

endpackage

// File: rtl/word_select.sv
// J:1 WIDTH-bit word multiplexer. Picks word i_idx out of the held block,
// word 0 being the least significant WIDTH bits.
// Ports:
//   i_hold  - held block, WIDTH*J bits
//   i_idx   - word index
//   o_word  - selected word (0 if the index is out of range)
module word_select #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned J     = 4,
  parameter int unsigned CW    = 2
) (
  input  logic [WIDTH*J-1:0] i_hold,
  input  logic [CW-1:0]      i_idx,
  output logic [WIDTH-1:0]   o_word
);

  always_comb begin
    o_word = '0;
    for (int i = 0; i < int'(J); i++) begin
      if (i_idx == CW'(i)) begin
        o_word = i_hold[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/buffer_unloader.sv
// Downstream stage of the circular buffer: pulls one J-word block whenever
// the buffer is non-empty and the stage is idle or finishing its last word,
// then serialises the block LSB word first on a valid/ready stream.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   buf_empty  - buffer empty flag
//   buf_data   - buffer parallel output, J words of WIDTH bits
//   rd_req     - one-cycle read strobe per block (buffer ld3)
//   ser_out    - current serial word
//   ser_valid  - ser_out holds a valid word
//   ser_ready  - consumer accepts the word
//   ser_last   - marks word J-1 of a block
//   busy       - stage is not idle
module buffer_unloader
  import buffer_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned J     = DefaultJ
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               buf_empty,
  input  logic [WIDTH*J-1:0] buf_data,
  output logic               rd_req,
  output logic [WIDTH-1:0]   ser_out,
  output logic               ser_valid,
  input  logic               ser_ready,
  output logic               ser_last,
  output logic               busy
);

  localparam int unsigned    CW      = cw_of(J);
  localparam logic [CW-1:0]  LastIdx = CW'(J - 1);

  state_e             r_state, w_state_d;
  logic [WIDTH*J-1:0] r_hold, w_hold_d;
  logic [CW-1:0]      r_idx, w_idx_d;

  logic w_send;
  logic w_at_last;
  logic w_hs;

  assign w_send    = (r_state == SEND);
  assign w_at_last = (r_idx == LastIdx);
  assign w_hs      = w_send & ser_ready;

  // Refill when idle, or on the last-word handshake for zero-bubble blocks.
  always_comb begin
    rd_req = !rst && !buf_empty && (!w_send || (w_hs && w_at_last));
  end

  always_comb begin
    w_state_d = r_state;
    w_hold_d  = r_hold;
    w_idx_d   = r_idx;
    if (rd_req) begin
      w_state_d = SEND;
      w_hold_d  = buf_data;
      w_idx_d   = '0;
    end else if (w_hs) begin
      if (!w_at_last) begin
        w_idx_d = r_idx + CW'(1);
      end else begin
        w_state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_d;
      r_hold  <= w_hold_d;
      r_idx   <= w_idx_d;
    end
  end

  word_select #(
    .WIDTH (WIDTH),
    .J     (J),
    .CW    (CW)
  ) u_word_select (
    .i_hold (r_hold),
    .i_idx  (r_idx),
    .o_word (ser_out)
  );

  assign ser_valid = w_send;
  assign ser_last  = w_send & w_at_last;
  assign busy      = w_send;

endmodule

// File: tb/tb_buffer_unloader.sv
// Self-checking bench for buffer_unloader (J=4 and J=1 instances).
// The reference treats the unloader as a word queue that is refilled with a
// whole block only when it is empty or its final word is leaving.
module tb_buffer_unloader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ser_ready = 1'b0;
  logic        empty4 = 1'b1, empty1 = 1'b1;
  logic [31:0] data4 = '0;
  logic [7:0]  data1 = '0;
  logic        rd4, rd1, v4, v1, l4, l1, b4, b1;
  logic [7:0]  out4, out1;

  always #5 clk = ~clk;

  buffer_unloader #(.WIDTH(8), .J(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .buf_empty (empty4),
    .buf_data  (data4),
    .rd_req    (rd4),
    .ser_out   (out4),
    .ser_valid (v4),
    .ser_ready (ser_ready),
    .ser_last  (l4),
    .busy      (b4)
  );

  buffer_unloader #(.WIDTH(8), .J(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .buf_empty (empty1),
    .buf_data  (data1),
    .rd_req    (rd1),
    .ser_out   (out1),
    .ser_valid (v1),
    .ser_ready (ser_ready),
    .ser_last  (l1),
    .busy      (b1)
  );

  int vectors = 0;
  int errors  = 0;

  logic        sel = 1'b0;        // 0: drive J=4 instance, 1: J=1 instance
  logic        force_empty = 1'b0;
  logic [31:0] q[$];              // buffer contents, one entry per block
  logic [7:0]  exp_words[$];      // words taken from the buffer, not yet delivered
  logic [7:0]  hs_log[$];
  int          rd_pos[$];
  int          rd_cnt, vcnt, last_cnt, first_v, last_v, seg_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_seg();
    hs_log.delete();
    rd_pos.delete();
    rd_cnt = 0; vcnt = 0; last_cnt = 0; first_v = -1; last_v = -1; seg_cyc = 0;
  endtask

  task automatic cycle(input logic rdy, input logic rst_v);
    logic [31:0] front, blk;
    logic        vis_empty, exp_rd, exp_v, o_rd, o_v, o_l, o_b;
    logic [7:0]  o_d;
    int          jc;
    @(negedge clk);
    rst       = rst_v;
    ser_ready = rdy;
    vis_empty = force_empty || (q.size() == 0);
    front     = (q.size() != 0) ? q[0] : $urandom();
    data4     = front;
    data1     = front[7:0];
    empty4    = sel ? 1'b1 : vis_empty;
    empty1    = sel ? vis_empty : 1'b1;
    #1;
    jc = sel ? 1 : 4;
    if (rst_v) exp_words.delete();
    exp_v  = (exp_words.size() != 0);
    exp_rd = !rst_v && !vis_empty &&
             (exp_words.size() == 0 || (exp_words.size() == 1 && rdy));
    o_rd = sel ? rd1 : rd4;
    o_v  = sel ? v1 : v4;
    o_l  = sel ? l1 : l4;
    o_b  = sel ? b1 : b4;
    o_d  = sel ? out1 : out4;
    chk("rd_req", 32'(o_rd), 32'(exp_rd));
    chk("ser_valid", 32'(o_v), 32'(exp_v));
    chk("busy", 32'(o_b), 32'(exp_v));
    chk("ser_last", 32'(o_l), 32'(exp_v && exp_words.size() == 1));
    if (exp_v) chk("ser_out", 32'(o_d), 32'(exp_words[0]));
    if (rst_v) chk("ser_out_rst", 32'(o_d), 32'h0);
    if (o_rd) begin
      rd_cnt++;
      rd_pos.push_back(seg_cyc);
    end
    if (o_v) begin
      vcnt++;
      if (first_v < 0) first_v = seg_cyc;
      last_v = seg_cyc;
      if (rdy) hs_log.push_back(o_d);
      if (rdy && o_l) last_cnt++;
    end
    if (exp_v && rdy) void'(exp_words.pop_front());
    if (exp_rd) begin
      blk = q.pop_front();
      for (int i = 0; i < jc; i++) exp_words.push_back(blk[i*8 +: 8]);
    end
    seg_cyc++;
  endtask

  initial begin
    logic [7:0] e_single[4];
    logic [7:0] e_bp[4];
    logic       bp_pat[6];
    e_single = '{8'h11, 8'h22, 8'h33, 8'h44};
    e_bp     = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    bp_pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    start_seg();

    // Reset values
    repeat (3) cycle(1'b1, 1'b1);
    chk("rst_out4", 32'(out4), 32'h0);
    repeat (2) cycle(1'b1, 1'b0);

    // Single block
    start_seg();
    q.push_back(32'h4433_2211);
    repeat (7) cycle(1'b1, 1'b0);
    chk("single_rd_cnt", 32'(rd_cnt), 32'd1);
    chk("single_words", 32'(hs_log.size()), 32'd4);
    for (int i = 0; i < hs_log.size() && i < 4; i++) chk("single_word", 32'(hs_log[i]), 32'(e_single[i]));
    chk("single_last", 32'(last_cnt), 32'd1);

    // Back-to-back, three blocks
    start_seg();
    repeat (3) q.push_back($urandom());
    repeat (15) cycle(1'b1, 1'b0);
    chk("b2b_rd_cnt", 32'(rd_cnt), 32'd3);
    if (rd_pos.size() == 3) begin
      chk("b2b_rd_gap1", 32'(rd_pos[1] - rd_pos[0]), 32'd4);
      chk("b2b_rd_gap2", 32'(rd_pos[2] - rd_pos[0]), 32'd8);
    end
    chk("b2b_valid_cnt", 32'(vcnt), 32'd12);
    chk("b2b_no_bubble", 32'(last_v - first_v + 1), 32'd12);
    chk("b2b_last", 32'(last_cnt), 32'd3);

    // Backpressure
    start_seg();
    q.push_back(32'hDDCC_BBAA);
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cycle(bp_pat[i], 1'b0);
    repeat (2) cycle(1'b1, 1'b0);
    chk("bp_rd_cnt", 32'(rd_cnt), 32'd1);
    chk("bp_words", 32'(hs_log.size()), 32'd4);
    for (int i = 0; i < hs_log.size() && i < 4; i++) chk("bp_word", 32'(hs_log[i]), 32'(e_bp[i]));

    // Empty flag rising on the last-word cycle
    start_seg();
    q.push_back($urandom());
    q.push_back($urandom());
    repeat (4) cycle(1'b1, 1'b0);
    force_empty = 1'b1;
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    chk("bnd_valid", 32'(v4), 32'h0);
    chk("bnd_busy", 32'(b4), 32'h0);
    chk("bnd_rd_cnt", 32'(rd_cnt), 32'd1);
    force_empty = 1'b0;
    repeat (6) cycle(1'b1, 1'b0);
    chk("bnd_rd_cnt2", 32'(rd_cnt), 32'd2);

    // Randomised traffic, stalls and empty glitches
    for (int n = 0; n < 400; n++) begin
      if (($urandom % 4) == 0 && q.size() < 4) q.push_back($urandom());
      force_empty = (($urandom % 8) == 0);
      cycle(($urandom % 4) != 0, 1'b0);
    end
    force_empty = 1'b0;
    repeat (30) cycle(1'b1, 1'b0);
    chk("drain_words", 32'(exp_words.size()), 32'd0);
    chk("drain_buffer", 32'(q.size()), 32'd0);

    // Reset in the middle of a block at word index 2
    start_seg();
    q.push_back($urandom());
    repeat (3) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    chk("midrst_valid", 32'(v4), 32'h0);
    chk("midrst_last", 32'(l4), 32'h0);
    cycle(1'b1, 1'b1);
    repeat (4) cycle(1'b1, 1'b0);
    chk("midrst_rd_cnt", 32'(rd_cnt), 32'd1);
    chk("midrst_valid_cnt", 32'(vcnt), 32'd2);

    // J = 1 instance
    sel = 1'b1;
    start_seg();
    q.push_back(32'h0000_00A5);
    q.push_back(32'h0000_00A5);
    repeat (5) cycle(1'b1, 1'b0);
    chk("j1_rd_cnt", 32'(rd_cnt), 32'd2);
    chk("j1_last_cnt", 32'(last_cnt), 32'd2);
    chk("j1_words", 32'(hs_log.size()), 32'd2);
    for (int i = 0; i < hs_log.size() && i < 2; i++) chk("j1_word", 32'(hs_log[i]), 32'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
